// File: rtl/simple_logic_deser_if.sv
// Bus interface for simple_logic_deser: serial input side plus parallel word and status strobes.
// The master modport belongs to whatever feeds the receiver; the slave modport is the receiver itself.
interface simple_logic_deser_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             din;
    logic             dinVld;
    logic [WIDTH-1:0] q;
    logic             qVld;
    logic             busy;
    logic             err;
    logic             perr;

    modport master (
        output start, din, dinVld,
        input  q, qVld, busy, err, perr
    );

    modport slave (
        input  start, din, dinVld,
        output q, qVld, busy, err, perr
    );
endinterface

// File: rtl/simple_logic_deser.sv
// simple_logic_deser: serial-to-parallel frame receiver.
// A start strobe opens a frame and WIDTH qualified bits are collected LSB first.
// The finished word is then presented on q with a one-cycle qVld strobe.
// A start seen mid-frame restarts the frame and raises a one-cycle err strobe.
// Optional feature macro: SIMPLE_LOGIC_DESER_PARITY_EN adds a trailing even-parity bit,
// a PARITY state and the perr strobe; without it perr is tied low.
// All outputs come straight from flops, so no input reaches an output combinationally.
module simple_logic_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    simple_logic_deser_if.slave bus
);

`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               qVld_q, qVld_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
    logic               perr_q, perr_d;
    logic               parityOk;
`endif

    logic               lastBit;
    logic [WIDTH-1:0]   capturedWord;

    // The bit currently on din dropped into the slot selected by the bit counter.
    assign capturedWord = (shiftReg_q & ~(WIDTH'(1) << cnt_q)) | (WIDTH'(bus.din) << cnt_q);
    assign lastBit      = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
    assign parityOk     = ~(^{shiftReg_q, bus.din});
`endif

    // State register and all registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shiftReg_q <= '0;
            word_q     <= '0;
            qVld_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shiftReg_q <= shiftReg_d;
            word_q     <= word_d;
            qVld_q     <= qVld_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    // Next state, bit counter and shift register; a start strobe always wins over bit capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shiftReg_d = shiftReg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    shiftReg_d = '0;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    cnt_d      = '0;
                    shiftReg_d = '0;
                end else if (bus.dinVld) begin
                    shiftReg_d = capturedWord;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (lastBit) begin
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
            PARITY: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    shiftReg_d = '0;
                end else if (bus.dinVld) begin
                    state_d = parityOk ? DONE : IDLE;
                end
            end
`endif
            DONE: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    shiftReg_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs: word, qVld, busy and the err/perr strobes.
    always_comb begin
        word_d = word_q;
        qVld_d = 1'b0;
        err_d  = 1'b0;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
        perr_d = 1'b0;
        busy_d = (state_d == SHIFT) || (state_d == PARITY);
`else
        busy_d = (state_d == SHIFT);
`endif
        case (state_q)
            SHIFT: begin
                if (bus.start) begin
                    err_d = 1'b1;
                end else if (bus.dinVld && lastBit) begin
`ifndef SIMPLE_LOGIC_DESER_PARITY_EN
                    word_d = capturedWord;
                    qVld_d = 1'b1;
`endif
                end
            end
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
            PARITY: begin
                if (bus.start) begin
                    err_d = 1'b1;
                end else if (bus.dinVld) begin
                    if (parityOk) begin
                        word_d = shiftReg_q;
                        qVld_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

    assign bus.q    = word_q;
    assign bus.qVld = qVld_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

endmodule

// File: tb/tb_simple_logic_deser.sv
// Testbench for simple_logic_deser.
// Expected words go into expQ when a frame is driven; a negedge monitor collects every
// word the receiver strobes out into obsQ, and the test tasks pair the two up.
module tb_simple_logic_deser;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk;
    logic rst_n;

    simple_logic_deser_if #(.WIDTH(WIDTH)) bus ();

    simple_logic_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] obsQ[$];
    int qVldCount    = 0;
    int errCount     = 0;
    int perrCount    = 0;
    int busyCount    = 0;
    int overlapCount = 0;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: counts strobes and busy cycles and captures every presented word.
    always @(negedge clk) begin
        if (bus.qVld) begin
            qVldCount++;
            obsQ.push_back(bus.q);
        end
        if (bus.err)  errCount++;
        if (bus.perr) perrCount++;
        if (bus.busy) busyCount++;
        if (bus.qVld && bus.err) overlapCount++;
    end

    // Drives one cycle of inputs on the falling edge, sampled at the next rising edge.
    task automatic applyStimulus(input logic s, input logic d, input logic v);
        @(negedge clk);
        bus.start  = s;
        bus.din    = d;
        bus.dinVld = v;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Start strobe, the data bits LSB first (optionally with 0-3 stall cycles before each),
    // and the even-parity bit when that feature is built.
    task automatic sendFrame(input logic [WIDTH-1:0] data, input bit withGaps);
        logic [WIDTH-1:0] sh;
        sh = data;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            if (withGaps) idleCycles($urandom_range(0, 3));
            applyStimulus(1'b0, sh[0], 1'b1);
            sh = sh >> 1;
        end
        if (EXTRA == 1) begin
            if (withGaps) idleCycles($urandom_range(0, 3));
            applyStimulus(1'b0, ^data, 1'b1);
        end
    endtask

    // Waits a bounded number of cycles for the monitor to capture a word.
    task automatic waitForWord(output bit found);
        for (int i = 0; i < 20 && obsQ.size() == 0; i++) @(posedge clk);
        found = (obsQ.size() != 0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q got %b want 0000", bus.q); end
        checks++; if (bus.qVld !== 1'b0) begin errors++; $display("[TB] FAIL reset_qVld got %b want 0", bus.qVld); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.perr !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr got %b want 0", bus.perr); end
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idleCycles(2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b want 0", bus.busy); end
        checks++; if (qVldCount !== 0) begin errors++; $display("[TB] FAIL post_reset_qvld_count got %0d want 0", qVldCount); end
    endtask

    task automatic test_basic_frame;
        int vld0, busy0;
        bit found;
        logic [WIDTH-1:0] exp, got;
        vld0  = qVldCount;
        busy0 = busyCount;
        expQ.push_back(4'b1101);
        sendFrame(4'b1101, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitForWord(found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL basic_timeout got no word want %b", expQ[0]);
            expQ.delete();
        end else begin
            exp = expQ.pop_front(); got = obsQ.pop_front();
            if (got !== exp) begin errors++; $display("[TB] FAIL basic_word got %b want %b", got, exp); end
        end
        idleCycles(3);
        checks++; if (qVldCount - vld0 !== 1) begin errors++; $display("[TB] FAIL basic_qvld_cycles got %0d want 1", qVldCount - vld0); end
        checks++; if (busyCount - busy0 !== WIDTH + EXTRA) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want %0d", busyCount - busy0, WIDTH + EXTRA); end
    endtask

    task automatic test_gaps;
        int vld0;
        bit found;
        logic [WIDTH-1:0] exp, got, sh;
        vld0 = qVldCount;
        sh = 4'b1101;
        expQ.push_back(4'b1101);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            idleCycles(i == WIDTH - 1 ? 3 : $urandom_range(0, 3));
            if (i == WIDTH - 1) begin
                checks++; if (qVldCount !== vld0) begin errors++; $display("[TB] FAIL gaps_early_qvld got %0d strobes want 0", qVldCount - vld0); end
            end
            applyStimulus(1'b0, sh[0], 1'b1);
            sh = sh >> 1;
        end
        if (EXTRA == 1) begin
            idleCycles(2);
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitForWord(found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL gaps_timeout got no word want %b", expQ[0]);
            expQ.delete();
        end else begin
            exp = expQ.pop_front(); got = obsQ.pop_front();
            if (got !== exp) begin errors++; $display("[TB] FAIL gaps_word got %b want %b", got, exp); end
        end
        idleCycles(2);
        checks++; if (qVldCount - vld0 !== 1) begin errors++; $display("[TB] FAIL gaps_qvld_count got %0d want 1", qVldCount - vld0); end
    endtask

    task automatic test_restart;
        int vld0, err0;
        bit found;
        logic [WIDTH-1:0] exp, got;
        vld0 = qVldCount;
        err0 = errCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expQ.push_back(4'b0110);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL restart_err_now got %b want 1", bus.err); end
        checks++; if (bus.q !== 4'b1101) begin errors++; $display("[TB] FAIL restart_q_held got %b want 1101", bus.q); end
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        if (EXTRA == 1) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitForWord(found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL restart_timeout got no word want %b", expQ[0]);
            expQ.delete();
        end else begin
            exp = expQ.pop_front(); got = obsQ.pop_front();
            if (got !== exp) begin errors++; $display("[TB] FAIL restart_word got %b want %b", got, exp); end
        end
        idleCycles(2);
        checks++; if (errCount - err0 !== 1) begin errors++; $display("[TB] FAIL restart_err_count got %0d want 1", errCount - err0); end
        checks++; if (qVldCount - vld0 !== 1) begin errors++; $display("[TB] FAIL restart_qvld_count got %0d want 1", qVldCount - vld0); end
    endtask

    task automatic test_back_to_back;
        int err0;
        bit found;
        logic [WIDTH-1:0] exp, got;
        err0 = errCount;
        expQ.push_back(4'b1010);
        expQ.push_back(4'b0101);
        sendFrame(4'b1010, 1'b0);
        sendFrame(4'b0101, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            waitForWord(found);
            checks++;
            if (!found) begin
                errors++; $display("[TB] FAIL b2b_timeout frame %0d got no word", k);
                expQ.delete();
            end else begin
                exp = expQ.pop_front(); got = obsQ.pop_front();
                if (got !== exp) begin errors++; $display("[TB] FAIL b2b_word%0d got %b want %b", k, got, exp); end
            end
        end
        idleCycles(2);
        checks++; if (errCount !== err0) begin errors++; $display("[TB] FAIL b2b_err_count got %0d want 0", errCount - err0); end
    endtask

`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
    task automatic test_parity;
        int vld0, perr0;
        bit found;
        logic [WIDTH-1:0] exp, got;
        expQ.push_back(4'b0111);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitForWord(found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL parity_ok_timeout got no word want 0111");
            expQ.delete();
        end else begin
            exp = expQ.pop_front(); got = obsQ.pop_front();
            if (got !== exp) begin errors++; $display("[TB] FAIL parity_ok_word got %b want %b", got, exp); end
        end
        idleCycles(2);
        vld0  = qVldCount;
        perr0 = perrCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idleCycles(3);
        checks++; if (perrCount - perr0 !== 1) begin errors++; $display("[TB] FAIL parity_bad_perr got %0d want 1", perrCount - perr0); end
        checks++; if (qVldCount !== vld0) begin errors++; $display("[TB] FAIL parity_bad_qvld got %0d want 0", qVldCount - vld0); end
        checks++; if (bus.q !== 4'b0111) begin errors++; $display("[TB] FAIL parity_bad_q_held got %b want 0111", bus.q); end
    endtask
`else
    task automatic test_parity;
        checks++; if (perrCount !== 0) begin errors++; $display("[TB] FAIL perr_absent got %0d strobes want 0", perrCount); end
        checks++; if (bus.perr !== 1'b0) begin errors++; $display("[TB] FAIL perr_tied got %b want 0", bus.perr); end
    endtask
`endif

    task automatic test_midframe_reset;
        int vld0;
        bit found;
        logic [WIDTH-1:0] exp, got;
        vld0 = qVldCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_q got %b want 0000", bus.q); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", bus.busy); end
        checks++; if (bus.qVld !== 1'b0) begin errors++; $display("[TB] FAIL midreset_qvld got %b want 0", bus.qVld); end
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        idleCycles(3);
        checks++; if (qVldCount !== vld0) begin errors++; $display("[TB] FAIL midreset_no_strobe got %0d want 0", qVldCount - vld0); end
        expQ.push_back(4'b1100);
        sendFrame(4'b1100, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitForWord(found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL midreset_timeout got no word want 1100");
            expQ.delete();
        end else begin
            exp = expQ.pop_front(); got = obsQ.pop_front();
            if (got !== exp) begin errors++; $display("[TB] FAIL midreset_word got %b want %b", got, exp); end
        end
        idleCycles(2);
    endtask

    // Runs every scenario in order, then the end-of-run consistency checks and the summary.
    initial begin
        bus.start  = 1'b0;
        bus.din    = 1'b0;
        bus.dinVld = 1'b0;
        rst_n      = 1'b0;
        test_reset();
        test_basic_frame();
        test_gaps();
        test_restart();
        test_back_to_back();
        test_parity();
        test_midframe_reset();
        checks++; if (overlapCount !== 0) begin errors++; $display("[TB] FAIL qvld_err_overlap got %0d want 0", overlapCount); end
        checks++; if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL spurious_words got %0d want 0", obsQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
